// File: rtl/m8c_issp_target.sv
`timescale 1ns/1ps
// M8C ISSP target model: device end of the SCLK/SDATA link. It decodes 22-bit host
// vectors into reads and writes of mem[256]/reg[256], and produces the POR
// acknowledge and the execute busy/ready handshake.
// Ports: osc/rst  24 MHz clock, async active-high reset
//        vdd_in, sclk_in, sdata_in  asynchronous pin inputs, each 2-FF synchronised
//        sdata_out/sdata_oe  SDATA drive value and enable
//        vec_count  completed vectors (wraps)
//        state  FSM encoding: 0 OFF, 1 POR_WAIT, 2 POR_LOW, 3 SHIFT,
//               4 EXEC_BUSY, 5 EXEC_READY, 6 EXEC_ZEROS
module m8c_issp_target #(
  parameter int         POR_DELAY      = 24000,
  parameter int         POR_LOW        = 8,
  parameter logic [7:0] EXEC_REG       = 8'hF7,
  parameter int         EXEC_BUSY_CLKS = 50,
  parameter int         ABORT_TIMEOUT  = 4800
) (
  input  logic       osc,
  input  logic       rst,
  input  logic       vdd_in,
  input  logic       sclk_in,
  input  logic       sdata_in,
  output logic       sdata_out,
  output logic       sdata_oe,
  output logic [7:0] vec_count,
  output logic [2:0] state
);

  // POR_DELAY is the longest count this shared counter ever holds.
  localparam int CW = $clog2(POR_DELAY + 1);
  localparam int IW = $clog2(ABORT_TIMEOUT + 1);
  localparam int EXEC_ZERO_CLKS = 40;

  typedef enum logic [2:0] {
    S_OFF        = 3'd0,
    S_POR_WAIT   = 3'd1,
    S_POR_LOW    = 3'd2,
    S_SHIFT      = 3'd3,
    S_EXEC_BUSY  = 3'd4,
    S_EXEC_READY = 3'd5,
    S_EXEC_ZEROS = 3'd6
  } state_t;

  logic r_vdd_s1, r_vdd_s2, r_sclk_s1, r_sclk_s2, r_sclk_s3, r_sd_s1, r_sd_s2;
  state_t r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [4:0]    r_bitcnt, w_bitcnt_n;
  logic [20:0]   r_shift, w_shift_n;
  logic [7:0]    r_tx, w_tx_n;
  logic          r_rd, w_rd_n;
  logic [IW-1:0] r_idle, w_idle_n;
  logic          r_oe, w_oe_n, r_out, w_out_n;
  logic [7:0]    r_vec_count, w_vec_n;
  logic          w_mem_we, w_reg_we;
  logic [7:0]    r_mem [256];
  logic [7:0]    r_regs [256];

  // Edge events come from the 2nd sync flop against a 3rd delay flop.
  logic w_rise, w_fall, w_abort;
  logic [21:0] w_vec;
  assign w_rise  = r_sclk_s2 & ~r_sclk_s3;
  assign w_fall  = ~r_sclk_s2 & r_sclk_s3;
  assign w_vec   = {r_shift, r_sd_s2};  // vector as it stands including this edge's bit
  assign w_abort = (r_state == S_SHIFT) && (r_bitcnt != 5'd0) &&
                   (r_idle == IW'(ABORT_TIMEOUT));

  always_ff @(posedge osc or posedge rst) begin
    if (rst) begin
      r_vdd_s1 <= 1'b0; r_vdd_s2 <= 1'b0;
      r_sclk_s1 <= 1'b0; r_sclk_s2 <= 1'b0; r_sclk_s3 <= 1'b0;
      r_sd_s1 <= 1'b0; r_sd_s2 <= 1'b0;
      r_state <= S_OFF;
      r_cnt <= '0;
      r_bitcnt <= '0;
      r_shift <= '0;
      r_tx <= '0;
      r_rd <= 1'b0;
      r_idle <= '0;
      r_oe <= 1'b0;
      r_out <= 1'b0;
      r_vec_count <= '0;
    end else begin
      r_vdd_s1 <= vdd_in;   r_vdd_s2 <= r_vdd_s1;
      r_sclk_s1 <= sclk_in; r_sclk_s2 <= r_sclk_s1; r_sclk_s3 <= r_sclk_s2;
      r_sd_s1 <= sdata_in;  r_sd_s2 <= r_sd_s1;
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_bitcnt <= w_bitcnt_n;
      r_shift <= w_shift_n;
      r_tx <= w_tx_n;
      r_rd <= w_rd_n;
      r_idle <= w_idle_n;
      r_oe <= w_oe_n;
      r_out <= w_out_n;
      r_vec_count <= w_vec_n;
    end
  end

  // Storage is deliberately not reset so contents survive rst and VDD loss.
  always_ff @(posedge osc) begin
    if (w_mem_we) r_mem[w_vec[18:11]] <= w_vec[9:2];
    if (w_reg_we) r_regs[w_vec[18:11]] <= w_vec[9:2];
  end

  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_bitcnt_n = r_bitcnt;
    w_shift_n  = r_shift;
    w_tx_n     = r_tx;
    w_rd_n     = r_rd;
    w_oe_n     = r_oe;
    w_out_n    = r_out;
    w_vec_n    = r_vec_count;
    w_idle_n   = r_idle;
    w_mem_we   = 1'b0;
    w_reg_we   = 1'b0;

    // Idle timer only runs in SHIFT and saturates at the abort threshold.
    if (r_state != S_SHIFT || w_rise || w_fall) w_idle_n = '0;
    else if (r_idle != IW'(ABORT_TIMEOUT))      w_idle_n = r_idle + 1'b1;

    if (!r_vdd_s2) begin
      // Supply loss overrides everything, including a coincident SCLK edge.
      w_state_n  = S_OFF;
      w_oe_n     = 1'b0;
      w_out_n    = 1'b0;
      w_bitcnt_n = '0;
      w_rd_n     = 1'b0;
    end else begin
      case (r_state)
        S_OFF: begin
          w_state_n = S_POR_WAIT;
          w_cnt_n   = CW'(POR_DELAY);
        end
        S_POR_WAIT: begin
          if (r_cnt <= CW'(1)) begin
            w_state_n = S_POR_LOW;
            w_oe_n    = 1'b1;
            w_out_n   = 1'b0;
            w_cnt_n   = CW'(POR_LOW);
          end else w_cnt_n = r_cnt - 1'b1;
        end
        S_POR_LOW: begin
          if (r_cnt <= CW'(1)) begin
            w_state_n  = S_SHIFT;
            w_oe_n     = 1'b0;
            w_bitcnt_n = '0;
            w_rd_n     = 1'b0;
          end else w_cnt_n = r_cnt - 1'b1;
        end
        S_SHIFT: begin
          if (w_abort) begin
            // Abort wins over an edge landing on the same cycle.
            w_bitcnt_n = '0;
            w_oe_n     = 1'b0;
            w_rd_n     = 1'b0;
          end else if (w_rise) begin
            w_shift_n = w_vec[20:0];
            // 12th edge: opcode and address sit in r_shift[10:0].
            if (r_bitcnt == 5'd11 && r_shift[10] && r_shift[8]) begin
              w_rd_n = 1'b1;
              w_tx_n = r_shift[9] ? r_regs[r_shift[7:0]] : r_mem[r_shift[7:0]];
            end
            if (r_bitcnt == 5'd21) begin
              w_bitcnt_n = '0;
              w_rd_n     = 1'b0;
              w_vec_n    = r_vec_count + 8'd1;
              if (w_vec[21] && !w_vec[19]) begin
                w_mem_we = !w_vec[20];
                w_reg_we = w_vec[20];
                if (w_vec[20] && w_vec[18:11] == EXEC_REG) begin
                  w_state_n = S_EXEC_BUSY;
                  w_cnt_n   = '0;
                end
              end
            end else w_bitcnt_n = r_bitcnt + 5'd1;
          end else if (w_fall && r_rd) begin
            // Falling after edge k (12..19) presents tx[19-k]; after edge 20 release.
            if (r_bitcnt >= 5'd12 && r_bitcnt <= 5'd19) begin
              w_oe_n  = 1'b1;
              w_out_n = r_tx[3'(5'd19 - r_bitcnt)];
            end else if (r_bitcnt == 5'd20) begin
              w_oe_n = 1'b0;
            end
          end
        end
        S_EXEC_BUSY: begin
          if (w_fall) begin
            w_oe_n  = 1'b1;
            w_out_n = 1'b1;
          end
          if (w_rise) begin
            if (r_cnt == CW'(EXEC_BUSY_CLKS - 1)) begin
              w_state_n = S_EXEC_READY;
              w_cnt_n   = '0;
            end else w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_EXEC_READY: begin
          // Low is presented on the falling edge so the host samples it on the next rise.
          if (w_fall) w_out_n = 1'b0;
          if (w_rise) begin
            w_state_n = S_EXEC_ZEROS;
            w_oe_n    = 1'b0;
            w_cnt_n   = '0;
          end
        end
        S_EXEC_ZEROS: begin
          if (w_rise) begin
            if (r_cnt == CW'(EXEC_ZERO_CLKS - 1)) begin
              w_state_n  = S_SHIFT;
              w_bitcnt_n = '0;
            end else w_cnt_n = r_cnt + 1'b1;
          end
        end
        default: w_state_n = S_OFF;
      endcase
    end
  end

  assign sdata_out = r_out;
  assign sdata_oe  = r_oe;
  assign vec_count = r_vec_count;
  assign state     = r_state;

endmodule
